// File: rtl/test_chain_sequencer.sv
// Clocked start->finish chain for N sub-tests: raises one start level per finished stage,
// with a per-stage watchdog, a saturating RUN-cycle count and pass/fail status.
module test_chain_sequencer #(
   parameter int unsigned N_STAGES = 14,
   parameter int unsigned TIMEOUT  = 65535,
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned IDX_W    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                go,
   input  logic [N_STAGES-1:0] finish_i,
   output logic [N_STAGES-1:0] start_o,
   output logic                busy,
   output logic                done,
   output logic                timeout_err,
   output logic [IDX_W-1:0]    fail_stage,
   output logic [CNT_W-1:0]    total_cycles
);

   localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone, StErr} state_e;

   state_e              state_q, state_d;
   logic [N_STAGES-1:0] start_q, start_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [TmoW-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]    total_q, total_d;
   logic [IDX_W-1:0]    fail_q, fail_d;
   logic [N_STAGES-1:0] stage_sel;
   logic                cur_finish;

   // One-hot of the active stage; finish bits of all other stages are masked off.
   assign stage_sel  = {{(N_STAGES-1){1'b0}}, 1'b1} << idx_q;
   assign cur_finish = |(finish_i & stage_sel);

   always_comb begin
      state_d = state_q;
      start_d = start_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      total_d = total_q;
      fail_d  = fail_q;
      unique case (state_q)
         StIdle, StDone, StErr: begin
            if (go) begin
               state_d = StRun;
               start_d = {{(N_STAGES-1){1'b0}}, 1'b1};
               idx_d   = '0;
               cnt_d   = '0;
               total_d = '0;
               fail_d  = '0;
            end
         end
         StRun: begin
            if (total_q != {CNT_W{1'b1}}) begin
               total_d = total_q + 1'b1;
            end
            // Finish takes priority over a watchdog expiring on the same edge.
            if (cur_finish) begin
               if (idx_q == IDX_W'(N_STAGES - 1)) begin
                  state_d = StDone;
               end else begin
                  start_d = start_q | (stage_sel << 1);
                  idx_d   = idx_q + 1'b1;
                  cnt_d   = '0;
               end
            end else if (cnt_q == TmoW'(TIMEOUT - 1)) begin
               state_d = StErr;
               fail_d  = idx_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         start_q <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         total_q <= '0;
         fail_q  <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         total_q <= total_d;
         fail_q  <= fail_d;
      end
   end

   assign start_o      = start_q;
   assign busy         = (state_q == StRun);
   assign done         = (state_q == StDone);
   assign timeout_err  = (state_q == StErr);
   assign fail_stage   = fail_q;
   assign total_cycles = total_q;

endmodule

// File: tb/tb_test_chain_sequencer.sv
// Directed bench for test_chain_sequencer: 4 stages, 8-edge watchdog, 4-bit cycle counter.
module tb_test_chain_sequencer;

   localparam int unsigned N  = 4;
   localparam int unsigned TO = 8;
   localparam int unsigned CW = 4;
   localparam int unsigned IW = 2;

   logic          clk;
   logic          rst_n;
   logic          go;
   logic [N-1:0]  finish_i;
   logic [N-1:0]  start_o;
   logic          busy;
   logic          done;
   logic          timeout_err;
   logic [IW-1:0] fail_stage;
   logic [CW-1:0] total_cycles;

   int n_checks = 0;
   int n_errors = 0;

   test_chain_sequencer #(
      .N_STAGES(N),
      .TIMEOUT (TO),
      .CNT_W   (CW),
      .IDX_W   (IW)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .go          (go),
      .finish_i    (finish_i),
      .start_o     (start_o),
      .busy        (busy),
      .done        (done),
      .timeout_err (timeout_err),
      .fail_stage  (fail_stage),
      .total_cycles(total_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs are driven and outputs sampled on the falling edge.
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_go();
      go = 1'b1;
      step(1);
      go = 1'b0;
   endtask

   // finish_i[i] is sampled high on the 'edges'-th rising edge after start_o[i] rose.
   task automatic run_stage(input int i, input int edges);
      step(edges - 1);
      finish_i[i] = 1'b1;
      step(1);
   endtask

   task automatic check_status(input string tag, input logic [N-1:0] st, input logic b,
                               input logic d, input logic e, input logic [IW-1:0] f,
                               input logic [CW-1:0] t);
      check_eq({tag, ".start"}, 32'(start_o), 32'(st));
      check_eq({tag, ".busy"}, 32'(busy), 32'(b));
      check_eq({tag, ".done"}, 32'(done), 32'(d));
      check_eq({tag, ".err"}, 32'(timeout_err), 32'(e));
      check_eq({tag, ".fail"}, 32'(fail_stage), 32'(f));
      check_eq({tag, ".total"}, 32'(total_cycles), 32'(t));
   endtask

   initial begin
      // 1: reset with random inputs, then idle with go low
      rst_n    = 1'b0;
      go       = 1'($urandom);
      finish_i = N'($urandom);
      step(2);
      go       = 1'($urandom);
      finish_i = N'($urandom);
      step(1);
      check_status("rst", 4'b0000, 0, 0, 0, 0, 0);
      rst_n    = 1'b1;
      go       = 1'b0;
      finish_i = '0;
      step(5);
      check_status("idle", 4'b0000, 0, 0, 0, 0, 0);

      // 2: four stages, 3 edges each
      pulse_go();
      check_status("go1", 4'b0001, 1, 0, 0, 0, 0);
      run_stage(0, 3);
      check_eq("s0.start", 32'(start_o), 32'h3);
      run_stage(1, 3);
      check_eq("s1.start", 32'(start_o), 32'h7);
      run_stage(2, 3);
      check_eq("s2.start", 32'(start_o), 32'hf);
      run_stage(3, 3);
      check_status("done1", 4'b1111, 0, 1, 0, 0, 12);
      step(3);
      check_status("done1.hold", 4'b1111, 0, 1, 0, 0, 12);

      // 4: finish_i[3] high before go; stage 3 then lasts one edge
      finish_i = 4'b1000;
      step(1);
      pulse_go();
      check_status("go4", 4'b0001, 1, 0, 0, 0, 0);
      run_stage(0, 3);
      check_eq("e3.s0.start", 32'(start_o), 32'h3);
      run_stage(1, 3);
      run_stage(2, 3);
      check_status("e3.s2", 4'b1111, 1, 0, 0, 0, 9);
      step(1);
      check_status("e3.done", 4'b1111, 0, 1, 0, 0, 10);

      // 6: restart from DONE; stage 0 finishes on the watchdog's last edge
      finish_i = '0;
      pulse_go();
      check_status("go6", 4'b0001, 1, 0, 0, 0, 0);
      step(7);
      check_status("wd.7", 4'b0001, 1, 0, 0, 0, 7);
      finish_i[0] = 1'b1;
      step(1);
      check_status("wd.8", 4'b0011, 1, 0, 0, 0, 8);
      run_stage(1, 3);
      run_stage(2, 3);
      run_stage(3, 3);
      check_status("sat.done", 4'b1111, 0, 1, 0, 0, 15);

      // 3: stage 2 never finishes
      finish_i = '0;
      pulse_go();
      run_stage(0, 3);
      run_stage(1, 3);
      step(7);
      check_status("to.7", 4'b0111, 1, 0, 0, 0, 13);
      step(1);
      check_status("to.8", 4'b0111, 0, 0, 1, 2, 14);
      step(3);
      check_status("to.hold", 4'b0111, 0, 0, 1, 2, 14);

      // 5: restart from ERR, go during RUN ignored, then async reset mid-stage 1
      finish_i = '0;
      pulse_go();
      check_status("go5", 4'b0001, 1, 0, 0, 0, 0);
      run_stage(0, 3);
      pulse_go();
      check_status("go.inrun", 4'b0011, 1, 0, 0, 0, 4);
      #2 rst_n = 1'b0;
      #1 check_status("arst", 4'b0000, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n    = 1'b1;
      finish_i = '0;
      step(2);
      check_status("post.rst", 4'b0000, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
